if_stage: RTL and testbench

- Instruction-fetch stage directly upstream of id_stage.
- Holds the PC and issues in-order requests to instruction memory over a valid/ready port, tolerating any response latency of 1 cycle or more.
- Buffers returned instructions with their PCs in a small FIFO and presents them to id_stage through a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing buffered and in-flight fetches.

---
 rtl/if_stage.sv | 121 ++++++++++++
 tb/tb_if_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, credit-limited imem requests, fetch buffer toward id_stage.
module if_stage #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_i,
  input  logic [DATA_WIDTH-1:0]  redirect_pc_i,
  output logic                   imem_req_valid_o,
  output logic [DATA_WIDTH-1:0]  imem_req_addr_o,
  input  logic                   imem_req_ready_i,
  input  logic                   imem_rsp_valid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0]  pc_o,
  input  logic                   id_ready_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0]  pc;
  logic [CW-1:0]          outstanding;
  logic [CW-1:0]          drop_cnt;
  logic [CW-1:0]          fifo_count;
  logic [AW-1:0]          fifo_wr;
  logic [AW-1:0]          fifo_rd;
  logic [AW-1:0]          pcq_wr;
  logic [AW-1:0]          pcq_rd;
  logic [INSTR_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  pc_mem    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  pcq_mem   [FIFO_DEPTH];

  logic          fifo_empty;
  logic [CW:0]   credit;
  logic          accept;
  logic          rsp;
  logic          drop;
  logic          push;
  logic          pop;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // Outstanding requests plus buffered entries never exceed the buffer size,
  // so every accepted request is guaranteed a slot when it returns.
  assign fifo_empty       = (fifo_count == '0);
  assign credit           = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid_o = rst && !redirect_i && (credit < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr_o  = pc;
  assign accept           = imem_req_valid_o && imem_req_ready_i;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp  = imem_rsp_valid_i && (outstanding != '0);
  assign drop = rsp && (drop_cnt != '0);
  assign push = rsp && !drop && !redirect_i;
  assign pop  = !fifo_empty && id_ready_i && !redirect_i;

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? '0 : instr_mem[fifo_rd];
  assign pc_o          = fifo_empty ? '0 : pc_mem[fifo_rd];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp);
      if (redirect_i) begin
        pc         <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
        drop_cnt   <= outstanding - CW'(rsp);
        fifo_count <= '0;
        fifo_wr    <= '0;
        fifo_rd    <= '0;
        pcq_wr     <= '0;
        pcq_rd     <= '0;
      end else begin
        if (accept) begin
          pc     <= pc + DATA_WIDTH'(4);
          pcq_wr <= pcq_wr + AW'(1);
        end
        if (drop) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          fifo_wr <= fifo_wr + AW'(1);
          pcq_rd  <= pcq_rd + AW'(1);
        end
        if (pop) begin
          fifo_rd <= fifo_rd + AW'(1);
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays need no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (accept) begin
      pcq_mem[pcq_wr] <= pc;
    end
    if (push) begin
      instr_mem[fifo_wr] <= imem_rsp_data_i;
      pc_mem[fifo_wr]    <= pcq_mem[pcq_rd];
    end
  end

  rsp_has_request_a: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid_i |-> (outstanding != '0));

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized bench for if_stage against a queue-based fetch model.
module tb_if_stage;

  localparam int DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        id_ready_i;

  if_stage #(.DATA_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
    .imem_req_ready_i(imem_req_ready_i), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .pc_o(pc_o), .id_ready_i(id_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        mem_q[$];
  ent_t        fq[$];
  logic [31:0] m_pc;
  int          cyc;
  int          last_due;
  int          lat_min = 1;
  int          lat_max = 1;
  int          checks = 0;
  int          errors = 0;

  int          dut_acc;
  bit          obs_acc;
  logic [31:0] obs_acc_addr;
  bit          obs_valid;
  logic [31:0] obs_pc;
  int          obs_cyc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc, input bit rr, input bit idr);
    bit   rsp;
    bit   exp_rv;
    bit   acc;
    int   due;
    req_t r;
    @(negedge clk);
    redirect_i       = redir;
    redirect_pc_i    = rpc;
    imem_req_ready_i = rr;
    id_ready_i       = idr;
    rsp              = (mem_q.size() > 0) && (mem_q[0].due == cyc);
    imem_rsp_valid_i = rsp;
    imem_rsp_data_i  = rsp ? mem_data(mem_q[0].addr) : 32'h0;
    #1;
    exp_rv = !redir && (mem_q.size() + fq.size() < DEPTH);
    check_eq("req_valid", imem_req_valid_o, exp_rv);
    check_eq("req_addr", imem_req_addr_o, m_pc);
    check_eq("instr_valid", instr_valid_o, fq.size() > 0);
    if (fq.size() > 0) begin
      check_eq("instr", instr_o, fq[0].instr);
      check_eq("pc", pc_o, fq[0].pc);
    end
    obs_acc      = imem_req_valid_o && rr;
    obs_acc_addr = imem_req_addr_o;
    obs_valid    = instr_valid_o;
    obs_pc       = pc_o;
    obs_cyc      = cyc;
    if (obs_acc) dut_acc++;

    // Reference: requests live in the memory queue until answered; a redirect
    // marks everything in flight stale and empties the delivery buffer.
    acc = exp_rv && rr;
    if (rsp) r = mem_q.pop_front();
    if (redir) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      fq.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (fq.size() > 0 && idr) void'(fq.pop_front());
      if (rsp && !r.stale) fq.push_back('{r.addr, mem_data(r.addr)});
      if (acc) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{m_pc, due, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic rand_step(input int p_rr, input int p_idr, input int p_redir);
    step($urandom_range(99, 0) < p_redir, $urandom(),
         $urandom_range(99, 0) < p_rr, $urandom_range(99, 0) < p_idr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst              = 1'b0;
    redirect_i       = 1'b0;
    redirect_pc_i    = 32'h0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'h0;
    id_ready_i       = 1'b0;
    #1;
    check_eq("rst_req_valid", imem_req_valid_o, 1'b0);
    check_eq("rst_instr_valid", instr_valid_o, 1'b0);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_pc", pc_o, 32'h0);
    mem_q.delete();
    fq.delete();
    m_pc     = RST_PC;
    last_due = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    cyc = 1;
  endtask

  initial begin
    int first_v;
    logic [31:0] first_acc;
    logic [31:0] first_pc;
    bit got_acc;
    bit got_pc;

    rst = 1'b0;
    cyc = 0;
    do_reset();

    // 1-cycle memory, always ready: first delivery in cycle 3.
    lat_min = 1; lat_max = 1;
    first_v = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (obs_valid && first_v == 0) first_v = obs_cyc;
    end
    check_eq("first_valid_cycle", first_v, 3);

    // Decode stalled: only DEPTH requests go out.
    do_reset();
    dut_acc = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("stall_accepts", dut_acc, DEPTH);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Memory not ready: address holds.
    dut_acc = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("notready_accepts", dut_acc, 0);

    // Redirect with two fetches in flight.
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10 && mem_q.size() < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    got_acc = 0; got_pc = 0; first_acc = 32'hFFFF_FFFF; first_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (obs_acc && !got_acc) begin got_acc = 1; first_acc = obs_acc_addr; end
      if (obs_valid && !got_pc) begin got_pc = 1; first_pc = obs_pc; end
    end
    check_eq("redir_first_addr", first_acc, 32'h100);
    check_eq("redir_first_pc", first_pc, 32'h100);

    // Redirect colliding with a response and a pop.
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 40; i++) begin
      if (fq.size() > 0 && mem_q.size() > 0 && mem_q[0].due == cyc) begin
        step(1'b1, 32'h0000_2000 + 32'($urandom_range(15, 0)), 1'b1, 1'b1);
        break;
      end
      step(1'b0, 32'h0, 1'b1, 1'b1);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized mix of latencies, stalls and redirects.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 2500; i++) rand_step(70, 60, 4);

    // Reset mid-stream with two outstanding fetches.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("pre_reset_outstanding", mem_q.size(), 2);
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 60; i++) rand_step(80, 70, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
